uart_wb_cfg_ctrl: RTL and testbench
===================================

Name: uart_wb_cfg_ctrl

Overview:
- Wishbone classic single-cycle master that owns the UART core's register port.
- After start_i it programs the 16550-compatible UART: DLAB set, divisor DLL/DLM, line control, FIFO control, interrupt enable.
- It then serves a byte-stream TX request interface: polls LSR.THRE and writes THR.
- Sits between system/test logic and the UART's wb_* slave pins; the UART is instantiated in 8-bit bus mode.

Parameters:
- DIVISOR, 16'd27, baud divisor written to DLM:DLL.
- LCR_VAL, 8'h03, line control value (8N1); bit7 is forced 0 in the final write.
- FCR_VAL, 8'h07, FIFO control (enable, clear RX/TX, trigger level 1).
- IER_VAL, 8'h00, interrupt enable value.
- ACK_TIMEOUT, 16, max cycles stb_o may wait for ack_i; must be ≥2.
- POLL_GAP, 4, idle cycles between consecutive LSR polls; must be ≥1.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- start_i  in  1  pulse: begin (re)configuration
- cfg_done_o  out  1  configuration complete; level
- tx_valid_i  in  1  TX byte offered
- tx_data_i  in  8  TX byte
- tx_ready_o  out  1  controller accepts TX byte this cycle
- err_o  out  1  sticky: bus ack timeout
- wb_adr_o  out  3  UART register address
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data
- wb_we_o  out  1  write enable
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_ack_i  in  1  acknowledge

Behaviour:
- Reset, synchronous on wb_clk_i: all outputs 0 at the first edge with wb_rst_i=1, including an in-flight cycle (stb/cyc drop). Clears state, err_o and cfg_done_o.
- Register map: THR=0, IER=1, FCR=2, LCR=3, LSR=5. With DLAB=1: DLL=0, DLM=1.
- Bus transaction, all master outputs registered:
  - cyc_o and stb_o rise together, with adr/dat/we stable.
  - Held until the cycle ack_i=1 is sampled; all deasserted on the next edge.
  - At least one idle cycle (stb_o=0) between transactions.
  - On read, wb_dat_i is captured in the ack cycle.
- Timeout: a counter starts when stb_o rises. If ACK_TIMEOUT cycles pass without ack, drop stb/cyc, set err_o=1, enter ERR, clear cfg_done_o.
- FSM states: IDLE, CFG_LCR_DL, CFG_DLL, CFG_DLM, CFG_LCR, CFG_FCR, CFG_IER, READY, TX_POLL, TX_GAP, TX_WR, ERR.
- Configuration sequence, IDLE --start_i--> six writes in fixed order, each a full transaction:
  - LCR = LCR_VAL|8'h80
  - DLL = DIVISOR[7:0]
  - DLM = DIVISOR[15:8]
  - LCR = LCR_VAL&8'h7F
  - FCR = FCR_VAL
  - IER = IER_VAL
  - Then READY with cfg_done_o=1.
  - With zero-wait ack (ack one cycle after stb) the sequence takes 6×3 = 18 cycles from the start_i edge to cfg_done_o=1.
- TX handshake:
  - tx_ready_o=1 only in READY and only while start_i=0.
  - On tx_valid_i & tx_ready_o, latch tx_data_i and go to TX_POLL.
- TX_POLL: read LSR.
  - If bit5 (THRE)=1, go to TX_WR: write THR = latched byte, then READY.
  - Otherwise go to TX_GAP for POLL_GAP idle cycles, then TX_POLL again.
  - Polling is unbounded; only timeout or reset exits.
- start_i arbitration:
  - start_i in IDLE, READY or ERR: begin configuration; err_o is cleared when configuration restarts from ERR.
  - start_i in any other state is ignored.
  - start_i and tx_valid_i in the same READY cycle: start_i wins and the byte is not accepted.
- cfg_done_o drops on the edge configuration restarts.
- tx_valid_i outside READY: no effect; the requester holds it.
- ack_i while stb_o=0: ignored.

Decomposition:
- Package uart_cfg_pkg:
  - register address localparams (THR, IER, FCR, LCR, LSR, DLL, DLM)
  - LSR_THRE_BIT=5, LCR_DLAB_BIT=7
  - FSM state enum
- Sub-module wb_single_master: one-shot request/done/err handshake, stb/cyc generation, timeout counter, read-data capture.
- The top FSM sequences register accesses through wb_single_master.

Test Plan:
- Reset → start_i pulse with a zero-wait slave model → exactly 6 writes: (3,8'h83), (0,8'h1B), (1,8'h00), (3,8'h03), (2,8'h07), (1,8'h00); cfg_done_o=1 on cycle 18; one idle cycle between each.
- READY, tx 8'hA5, LSR returns 8'h60 → one LSR read then write (0,8'hA5); tx_ready_o low throughout and high again after.
- LSR returns 8'h00 twice then 8'h20 → three reads separated by ≥4 idle cycles, then THR write of the byte.
- Slave never acks during the DLM write → stb/cyc drop after 16 cycles, err_o=1, cfg_done_o=0; then start_i → full sequence reruns and err_o clears.
- wb_rst_i asserted while stb_o=1 mid-config → next edge: all outputs 0; no further bus activity until start_i.
- start_i and tx_valid_i in the same READY cycle → byte not accepted; reconfiguration writes begin.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// Shared constants and FSM encoding for the UART configuration controller.
// Register addresses follow the 16550 layout with the bus in 8-bit mode.
package uart_cfg_pkg;

  localparam logic [2:0] REG_THR = 3'd0;
  localparam logic [2:0] REG_IER = 3'd1;
  localparam logic [2:0] REG_FCR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3;
  localparam logic [2:0] REG_LSR = 3'd5;
  localparam logic [2:0] REG_DLL = 3'd0;
  localparam logic [2:0] REG_DLM = 3'd1;

  localparam int LSR_THRE_BIT = 5;
  localparam int LCR_DLAB_BIT = 7;

  typedef enum logic [3:0] {
    IDLE, CFG_LCR_DL, CFG_DLL, CFG_DLM, CFG_LCR, CFG_FCR, CFG_IER,
    READY, TX_POLL, TX_GAP, TX_WR, ERR
  } state_e;

endpackage

// File: rtl/wb_single_master.sv
// One-shot Wishbone classic master: launches a registered cycle on req,
// reports done on the ack cycle, or timeout if ack never arrives.
module wb_single_master #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic [2:0] adr,
  input  logic [7:0] wdat,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rdata,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  localparam int CW = $clog2(ACK_TIMEOUT);

  logic [CW-1:0] cnt;
  logic [7:0]    rdata_q;

  assign done    = wb_stb_o & wb_ack_i;
  assign timeout = wb_stb_o & ~wb_ack_i & (cnt == CW'(ACK_TIMEOUT - 1));
  // Read data is usable by the sequencer in the ack cycle itself
  assign rdata   = done ? wb_dat_i : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      cnt      <= '0;
      rdata_q  <= '0;
    end else if (wb_stb_o) begin
      if (done || timeout) begin
        wb_stb_o <= 1'b0;
        wb_cyc_o <= 1'b0;
        wb_we_o  <= 1'b0;
        wb_adr_o <= '0;
        wb_dat_o <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (done) rdata_q <= wb_dat_i;
    end else if (req) begin
      // Launch only from idle, so consecutive cycles always get a gap
      wb_stb_o <= 1'b1;
      wb_cyc_o <= 1'b1;
      wb_we_o  <= we;
      wb_adr_o <= adr;
      wb_dat_o <= wdat;
      cnt      <= '0;
    end
  end

endmodule

// File: rtl/uart_wb_cfg_ctrl.sv
// Programs a 16550 UART over Wishbone after start_i, then forwards TX bytes
// by polling LSR.THRE and writing THR.
module uart_wb_cfg_ctrl
  import uart_cfg_pkg::*;
#(
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter logic [7:0]  FCR_VAL     = 8'h07,
  parameter logic [7:0]  IER_VAL     = 8'h00,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          POLL_GAP    = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       start_i,
  output logic       cfg_done_o,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       err_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i
);

  localparam int         GW        = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [7:0] DLAB_MASK = 8'(1 << LCR_DLAB_BIT);

  state_e        state, nxt;
  logic          req, we, done, timeout, start_ok;
  logic [2:0]    adr;
  logic [7:0]    wdat, rdata, tx_byte;
  logic [GW-1:0] gap_cnt;
  logic          rdata_unused;

  assign rdata_unused = ^{rdata[7:LSR_THRE_BIT+1], rdata[LSR_THRE_BIT-1:0]};
  assign start_ok     = start_i & (state == IDLE || state == READY || state == ERR);

  wb_single_master #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_mst (
    .clk(wb_clk_i), .rst(wb_rst_i), .req(req), .we(we), .adr(adr), .wdat(wdat),
    .done(done), .timeout(timeout), .rdata(rdata),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt        = state;
    req        = 1'b0;
    we         = 1'b1;
    adr        = REG_THR;
    wdat       = '0;
    tx_ready_o = 1'b0;
    case (state)
      IDLE: ;
      CFG_LCR_DL: begin
        req = 1'b1; adr = REG_LCR; wdat = LCR_VAL | DLAB_MASK;
        if (done) nxt = CFG_DLL;
      end
      CFG_DLL: begin
        req = 1'b1; adr = REG_DLL; wdat = DIVISOR[7:0];
        if (done) nxt = CFG_DLM;
      end
      CFG_DLM: begin
        req = 1'b1; adr = REG_DLM; wdat = DIVISOR[15:8];
        if (done) nxt = CFG_LCR;
      end
      CFG_LCR: begin
        req = 1'b1; adr = REG_LCR; wdat = LCR_VAL & ~DLAB_MASK;
        if (done) nxt = CFG_FCR;
      end
      CFG_FCR: begin
        req = 1'b1; adr = REG_FCR; wdat = FCR_VAL;
        if (done) nxt = CFG_IER;
      end
      CFG_IER: begin
        req = 1'b1; adr = REG_IER; wdat = IER_VAL;
        if (done) nxt = READY;
      end
      READY: begin
        tx_ready_o = ~start_i;
        if (!start_i && tx_valid_i) nxt = TX_POLL;
      end
      TX_POLL: begin
        req = 1'b1; we = 1'b0; adr = REG_LSR;
        if (done) nxt = rdata[LSR_THRE_BIT] ? TX_WR : TX_GAP;
      end
      TX_GAP: if (gap_cnt == GW'(POLL_GAP - 1)) nxt = TX_POLL;
      TX_WR: begin
        req = 1'b1; adr = REG_THR; wdat = tx_byte;
        if (done) nxt = READY;
      end
      ERR: ;
      default: nxt = IDLE;
    endcase
    if (timeout)  nxt = ERR;
    if (start_ok) nxt = CFG_LCR_DL;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gap_cnt    <= '0;
      tx_byte    <= '0;
      cfg_done_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      gap_cnt <= (state == TX_GAP) ? gap_cnt + 1'b1 : '0;
      if (state == READY && !start_i && tx_valid_i) tx_byte <= tx_data_i;
      if (start_ok) begin
        cfg_done_o <= 1'b0;
        err_o      <= 1'b0;
      end else if (timeout) begin
        cfg_done_o <= 1'b0;
        err_o      <= 1'b1;
      end else if (state == CFG_IER && done) begin
        cfg_done_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_wb_cfg_ctrl.sv
// Scoreboard bench: stimulus queues expected bus transactions, a negedge
// monitor pops and compares them on every acked cycle.
module tb_uart_wb_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cfg_done;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       err;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i = 8'h00;
  logic       wb_we_o, wb_stb_o, wb_cyc_o;
  logic       wb_ack_i = 1'b0;

  typedef struct packed {logic we; logic [2:0] adr; logic [7:0] dat;} txn_t;
  txn_t       exp_q[$];
  logic [7:0] lsr_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         hang = 1'b0;

  always #5 clk = ~clk;

  uart_wb_cfg_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .cfg_done_o(cfg_done),
    .tx_valid_i(tx_valid), .tx_data_i(tx_data), .tx_ready_o(tx_ready), .err_o(err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Registered slave: ack one cycle after stb, optionally hangs on the DLM write
  always @(posedge clk) begin
    if (wb_stb_o && !wb_ack_i &&
        !(hang && wb_we_o && wb_adr_o == 3'd1 && wb_dat_o == 8'h00)) begin
      wb_ack_i <= 1'b1;
      if (!wb_we_o) wb_dat_i <= (lsr_q.size() > 0) ? lsr_q.pop_front() : 8'h20;
    end else begin
      wb_ack_i <= 1'b0;
    end
  end

  int   idle = 100;
  int   rises = 0;
  bit   prev_stb = 1'b0;
  bit   prev_rd = 1'b0;
  txn_t e;

  always @(negedge clk) begin
    if (wb_stb_o && !prev_stb) begin
      rises++;
      if (prev_rd && !wb_we_o) chk("poll_gap_ge4", idle >= 4, 1);
      else                     chk("idle_gap_ge1", idle >= 1, 1);
      idle = 0;
    end
    if (!wb_stb_o) idle++;
    if (wb_stb_o && wb_ack_i) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_txn: got we=%0b adr=%0d dat=%0h expected none",
                 wb_we_o, wb_adr_o, wb_dat_o);
      end else begin
        e = exp_q.pop_front();
        chk("txn_we", wb_we_o, e.we);
        chk("txn_adr", wb_adr_o, e.adr);
        chk("txn_cyc", wb_cyc_o, 1);
        if (e.we) chk("txn_dat", wb_dat_o, e.dat);
      end
      prev_rd = !wb_we_o;
    end
    prev_stb = wb_stb_o;
  end

  task automatic push(input logic w, input logic [2:0] a, input logic [7:0] d);
    exp_q.push_back('{we: w, adr: a, dat: d});
  endtask

  task automatic push_cfg();
    push(1, 3, 8'h83); push(1, 0, 8'h1B); push(1, 1, 8'h00);
    push(1, 3, 8'h03); push(1, 2, 8'h07); push(1, 1, 8'h00);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cfg(input string nm);
    int n = 0;
    while (!cfg_done && n < 100) begin @(negedge clk); n++; end
    chk(nm, cfg_done, 1);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!tx_ready && n < 300) begin @(negedge clk); n++; end
    chk(nm, tx_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    tx_data = b; tx_valid = 1'b1;
    #1 chk("tx_ready_before", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_ready_busy", tx_ready, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_stb"}, wb_stb_o, 0); chk({nm, "_cyc"}, wb_cyc_o, 0);
    chk({nm, "_we"}, wb_we_o, 0);   chk({nm, "_adr"}, wb_adr_o, 0);
    chk({nm, "_dat"}, wb_dat_o, 0); chk({nm, "_done"}, cfg_done, 0);
    chk({nm, "_err"}, err, 0);      chk({nm, "_rdy"}, tx_ready, 0);
  endtask

  initial begin
    int n, hi, r0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Configuration with zero-wait slave: done exactly 18 edges after start
    push_cfg();
    pulse_start();
    repeat (17) @(negedge clk);
    chk("cfg_done_at_17", cfg_done, 0);
    @(negedge clk);
    chk("cfg_done_at_18", cfg_done, 1);
    chk("ready_after_cfg", tx_ready, 1);
    chk("cfg_q_empty", exp_q.size(), 0);

    // THRE already set: one poll then the THR write
    lsr_q.push_back(8'h60);
    push(0, 5, 8'h00); push(1, 0, 8'hA5);
    send_byte(8'hA5);
    wait_ready("tx1_ready_back");
    chk("tx1_q_empty", exp_q.size(), 0);

    // THRE clear twice: three polls with gaps before the write
    lsr_q.push_back(8'h00); lsr_q.push_back(8'h00); lsr_q.push_back(8'h20);
    push(0, 5, 8'h00); push(0, 5, 8'h00); push(0, 5, 8'h00); push(1, 0, 8'h3C);
    send_byte(8'h3C);
    wait_ready("tx2_ready_back");
    chk("tx2_q_empty", exp_q.size(), 0);

    // Slave hangs on DLM: 16-cycle strobe, then ERR
    hang = 1'b1;
    push(1, 3, 8'h83); push(1, 0, 8'h1B);
    pulse_start();
    chk("restart_done_drop", cfg_done, 0);
    n = 0;
    while (!(wb_stb_o && wb_adr_o == 3'd1) && n < 100) begin @(negedge clk); n++; end
    hi = 0;
    while (wb_stb_o && hi < 100) begin hi++; @(negedge clk); end
    chk("timeout_stb_len", hi, 16);
    chk("timeout_err", err, 1);
    chk("timeout_done", cfg_done, 0);
    chk("timeout_cyc", wb_cyc_o, 0);
    chk("err_not_ready", tx_ready, 0);
    chk("timeout_q_empty", exp_q.size(), 0);
    hang = 1'b0;
    repeat (3) @(negedge clk);
    push_cfg();
    pulse_start();
    chk("err_cleared", err, 0);
    wait_cfg("recfg_done");
    chk("recfg_err", err, 0);
    chk("recfg_q_empty", exp_q.size(), 0);

    // Reset while a cycle is in flight
    push(1, 3, 8'h83);
    pulse_start();
    n = 0;
    while (!(wb_stb_o && wb_we_o && wb_adr_o == 3'd0) && n < 100) begin @(negedge clk); n++; end
    chk("rst_found_stb", wb_stb_o, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    r0 = rises;
    tx_valid = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_no_ready", tx_ready, 0);
    chk("post_rst_no_bus", rises, r0);
    tx_valid = 1'b0;
    chk("rst_q_empty", exp_q.size(), 0);

    // start_i beats tx_valid_i in READY
    push_cfg();
    pulse_start();
    wait_cfg("cfg3_done");
    push_cfg();
    start = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
    #1 chk("start_blocks_ready", tx_ready, 0);
    @(negedge clk);
    start = 1'b0; tx_valid = 1'b0;
    chk("start_drops_done", cfg_done, 0);
    wait_cfg("cfg4_done");
    repeat (10) @(negedge clk);
    chk("final_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
